// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit: operation codes,
// FSM states and the raw-opcode decode used when an operation is accepted.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_DIV = 2'b01,
        OP_MOD = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ITER = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    // The reserved encoding executes as a multiply, so it is folded here.
    function automatic op_e decode_op(input logic [1:0] raw);
        case (raw)
            2'b01:   decode_op = OP_DIV;
            2'b10:   decode_op = OP_MOD;
            default: decode_op = OP_MUL;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the magnitude datapath: a shift-add step for multiply or a
// restoring shift-subtract step for divide, MSB first.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] acc_i,
    input  logic [WIDTH:0] operand_i,
    input  logic           bit_i,
    input  logic           div_mode_i,
    output logic [WIDTH:0] acc_o,
    output logic           bit_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   addend;
    logic [WIDTH+1:0] sum;
    logic [WIDTH+1:0] diff;
    logic             no_borrow;

    // Divide shifts the next dividend bit in; multiply doubles the partial product.
    assign shifted   = {acc_i, div_mode_i ? bit_i : 1'b0};
    assign addend    = bit_i ? operand_i : '0;
    assign sum       = shifted + {1'b0, addend};
    assign diff      = shifted - {1'b0, operand_i};
    assign no_borrow = ~diff[WIDTH+1];

    always_comb begin
        acc_o = sum[WIDTH:0];
        bit_o = sum[WIDTH+1];
        if (div_mode_i) begin
            acc_o = no_borrow ? diff[WIDTH:0] : shifted[WIDTH:0];
            bit_o = no_borrow;
        end
    end

endmodule

// File: rtl/seq_muldiv.sv
// Iterative signed MUL/DIV/MOD unit: works on operand magnitudes for WIDTH
// cycles, then applies signs and divide-by-zero rules in a single fix-up cycle.
module seq_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div0
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q,  state_d;
    op_e              op_q,     op_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH:0]   a_mag_q,  a_mag_d;
    logic [WIDTH:0]   b_mag_q,  b_mag_d;
    logic [WIDTH:0]   acc_q,    acc_d;
    logic [WIDTH-1:0] quo_q,    quo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             div0_q,   div0_d;

    // One extra bit keeps |MIN| representable as a positive number.
    logic [WIDTH:0]   a_ext, b_ext, a_abs, b_abs;
    assign a_ext = {a[WIDTH-1], a};
    assign b_ext = {b[WIDTH-1], b};
    assign a_abs = a[WIDTH-1] ? -a_ext : a_ext;
    assign b_abs = b[WIDTH-1] ? -b_ext : b_ext;

    logic             step_div;
    logic [WIDTH-1:0] a_low, b_low;
    logic             step_bit_in;
    logic [WIDTH:0]   step_operand;
    logic [WIDTH:0]   step_acc;
    logic             step_bit;

    assign step_div     = (op_q != OP_MUL);
    assign a_low        = a_mag_q[WIDTH-1:0];
    assign b_low        = b_mag_q[WIDTH-1:0];
    assign step_bit_in  = step_div ? a_low[cnt_q] : b_low[cnt_q];
    assign step_operand = step_div ? b_mag_q : a_mag_q;

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc_i      (acc_q),
        .operand_i  (step_operand),
        .bit_i      (step_bit_in),
        .div_mode_i (step_div),
        .acc_o      (step_acc),
        .bit_o      (step_bit)
    );

    logic             negate;
    logic             b_zero;
    logic [WIDTH-1:0] low_acc;
    logic [WIDTH-1:0] a_back;
    logic [WIDTH-1:0] fix_result;

    assign negate  = sign_a_q ^ sign_b_q;
    assign b_zero  = (b_mag_q == '0);
    assign low_acc = acc_q[WIDTH-1:0];
    assign a_back  = sign_a_q ? -a_low : a_low;

    // Remainder follows the dividend's sign; quotient and product follow sign(a)^sign(b).
    always_comb begin
        case (op_q)
            OP_DIV:  fix_result = b_zero ? '1 : (negate ? -quo_q : quo_q);
            OP_MOD:  fix_result = b_zero ? a_back : (sign_a_q ? -low_acc : low_acc);
            default: fix_result = negate ? -low_acc : low_acc;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        acc_d    = acc_q;
        quo_d    = quo_q;
        result_d = result_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        div0_d   = div0_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d  = S_ITER;
                    op_d     = decode_op(op);
                    cnt_d    = CW'(WIDTH - 1);
                    a_mag_d  = a_abs;
                    b_mag_d  = b_abs;
                    sign_a_d = a[WIDTH-1];
                    sign_b_d = b[WIDTH-1];
                    acc_d    = '0;
                    quo_d    = '0;
                    div0_d   = 1'b0;
                end
            end
            S_ITER: begin
                acc_d = step_acc;
                if (step_div) begin
                    quo_d = {quo_q[WIDTH-2:0], step_bit};
                end
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                result_d = fix_result;
                div0_d   = step_div && b_zero;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            acc_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            acc_q    <= acc_d;
            quo_q    <= quo_d;
            result_q <= result_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            div0_q   <= div0_d;
        end
    end

    assign busy   = (state_q == S_ITER) || (state_q == S_FIX);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign div0   = div0_q;

endmodule

// File: tb/tb_seq_muldiv.sv
// Directed bench driving a 32-bit and an 8-bit seq_muldiv side by side with
// hand-computed expectations for results, flags, latency and busy duration.
module tb_seq_muldiv;

    logic        clk;
    logic        rst;
    logic        start32, start8;
    logic [1:0]  op32, op8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic        busy32, busy8, done32, done8, div032, div08;
    logic [31:0] res32;
    logic [7:0]  res8;

    int checks = 0;
    int errors = 0;

    int          lat   [2];
    int          lat2  [2];
    int          busyn [2];
    int          ndone [2];
    logic [31:0] r1    [2];
    logic [31:0] r2    [2];
    logic        d1    [2];

    seq_muldiv #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .result(res32), .div0(div032)
    );

    seq_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .div0(div08)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv);
        op32 = op; a32 = av; b32 = bv; start32 = 1'b1;
        op8 = op;  a8 = av[7:0]; b8 = bv[7:0]; start8 = 1'b1;
    endtask

    // Cycle n of the window is the state after the n-th edge following issue().
    task automatic run_window(input int ncyc, input bit inject, input bit chain, input bit do_rst);
        for (int k = 0; k < 2; k++) begin
            lat[k] = 0; lat2[k] = 0; busyn[k] = 0; ndone[k] = 0;
            r1[k] = '0; r2[k] = '0; d1[k] = 1'b0;
        end
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(posedge clk);
            #1;
            start32 = 1'b0;
            start8  = 1'b0;
            if (busy32) busyn[0]++;
            if (busy8)  busyn[1]++;
            if (done32) begin
                ndone[0]++;
                if (ndone[0] == 1) begin
                    lat[0] = cyc; r1[0] = res32; d1[0] = div032;
                    if (chain) begin
                        start32 = 1'b1; op32 = 2'b00; a32 = 32'd12; b32 = -32'sd11;
                    end
                end else begin
                    lat2[0] = cyc - lat[0]; r2[0] = res32;
                end
            end
            if (done8) begin
                ndone[1]++;
                if (ndone[1] == 1) begin
                    lat[1] = cyc; r1[1] = {24'h0, res8}; d1[1] = div08;
                    if (chain) begin
                        start8 = 1'b1; op8 = 2'b00; a8 = 8'd12; b8 = 8'hF5;
                    end
                end else begin
                    lat2[1] = cyc - lat[1]; r2[1] = {24'h0, res8};
                end
            end
            if (inject && cyc == 5) begin
                op32 = 2'b01; a32 = 32'd50; b32 = 32'd5; start32 = 1'b1;
                op8  = 2'b01; a8  = 8'd50;  b8  = 8'd5;  start8  = 1'b1;
            end
            if (do_rst && cyc == 5) rst = 1'b1;
            if (do_rst && cyc == 6) begin
                chk("rst_mid_busy32", {31'h0, busy32}, 32'h0);
                chk("rst_mid_done32", {31'h0, done32}, 32'h0);
                chk("rst_mid_res32", res32, 32'h0);
                chk("rst_mid_busy8", {31'h0, busy8}, 32'h0);
                chk("rst_mid_done8", {31'h0, done8}, 32'h0);
                chk("rst_mid_res8", {24'h0, res8}, 32'h0);
                rst = 1'b0;
            end
        end
    endtask

    task automatic check_case(input string tag, input logic [31:0] e32, input logic [7:0] e8, input logic ed0);
        chk({tag, "_lat32"}, lat[0], 32'd34);
        chk({tag, "_lat8"}, lat[1], 32'd10);
        chk({tag, "_busy32"}, busyn[0], 32'd33);
        chk({tag, "_busy8"}, busyn[1], 32'd9);
        chk({tag, "_ndone32"}, ndone[0], 32'd1);
        chk({tag, "_ndone8"}, ndone[1], 32'd1);
        chk({tag, "_res32"}, r1[0], e32);
        chk({tag, "_res8"}, r1[1], {24'h0, e8});
        chk({tag, "_div0_32"}, {31'h0, d1[0]}, {31'h0, ed0});
        chk({tag, "_div0_8"}, {31'h0, d1[1]}, {31'h0, ed0});
        chk({tag, "_hold32"}, res32, e32);
        chk({tag, "_hold8"}, {24'h0, res8}, {24'h0, e8});
        $display("case %s: res32=%h res8=%h div0=%0d/%0d lat=%0d/%0d", tag, r1[0], r1[1][7:0], d1[0], d1[1], lat[0], lat[1]);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        start32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;
        start8  = 1'b0; op8  = 2'b00; a8  = '0; b8  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy32", {31'h0, busy32}, 32'h0);
        chk("reset_done32", {31'h0, done32}, 32'h0);
        chk("reset_res32", res32, 32'h0);
        chk("reset_div0_32", {31'h0, div032}, 32'h0);
        chk("reset_busy8", {31'h0, busy8}, 32'h0);
        chk("reset_res8", {24'h0, res8}, 32'h0);
        rst = 1'b0;

        issue(2'b00, 32'd7, -32'sd3);          run_window(45, 0, 0, 0);
        check_case("mul_7_m3", 32'hFFFF_FFEB, 8'hEB, 1'b0);
        issue(2'b01, -32'sd7, 32'd2);          run_window(45, 0, 0, 0);
        check_case("div_m7_2", 32'hFFFF_FFFD, 8'hFD, 1'b0);
        issue(2'b10, -32'sd7, 32'd2);          run_window(45, 0, 0, 0);
        check_case("mod_m7_2", 32'hFFFF_FFFF, 8'hFF, 1'b0);
        issue(2'b10, 32'd7, -32'sd2);          run_window(45, 0, 0, 0);
        check_case("mod_7_m2", 32'h0000_0001, 8'h01, 1'b0);
        issue(2'b01, 32'd5, 32'd0);            run_window(45, 0, 0, 0);
        check_case("div_5_0", 32'hFFFF_FFFF, 8'hFF, 1'b1);
        issue(2'b10, 32'd5, 32'd0);            run_window(45, 0, 0, 0);
        check_case("mod_5_0", 32'h0000_0005, 8'h05, 1'b1);
        issue(2'b00, 32'd2, 32'd3);            run_window(45, 0, 0, 0);
        check_case("mul_2_3", 32'h0000_0006, 8'h06, 1'b0);
        issue(2'b01, 32'h8000_0000, -32'sd1);  a8 = 8'h80; run_window(45, 0, 0, 0);
        check_case("div_min_m1", 32'h8000_0000, 8'h80, 1'b0);
        issue(2'b00, 32'h8000_0000, -32'sd1);  a8 = 8'h80; run_window(45, 0, 0, 0);
        check_case("mul_min_m1", 32'h8000_0000, 8'h80, 1'b0);
        issue(2'b10, 32'h8000_0000, -32'sd1);  a8 = 8'h80; run_window(45, 0, 0, 0);
        check_case("mod_min_m1", 32'h0000_0000, 8'h00, 1'b0);
        issue(2'b01, 32'd100, 32'd7);          run_window(45, 1, 0, 0);
        check_case("div_100_7_ignore", 32'h0000_000E, 8'h0E, 1'b0);
        issue(2'b11, 32'd3, 32'd4);            run_window(45, 0, 0, 0);
        check_case("rsv_3_4", 32'h0000_000C, 8'h0C, 1'b0);

        // Second op issued in the DONE cycle of a MOD; its MUL wraps at 8 bits.
        issue(2'b10, -32'sd100, 32'd7);        run_window(80, 0, 1, 0);
        chk("chain_ndone32", ndone[0], 32'd2);
        chk("chain_ndone8", ndone[1], 32'd2);
        chk("chain_lat32", lat[0], 32'd34);
        chk("chain_lat8", lat[1], 32'd10);
        chk("chain_lat2_32", lat2[0], 32'd34);
        chk("chain_lat2_8", lat2[1], 32'd10);
        chk("chain_r1_32", r1[0], 32'hFFFF_FFFE);
        chk("chain_r1_8", r1[1], 32'h0000_00FE);
        chk("chain_r2_32", r2[0], 32'hFFFF_FF7C);
        chk("chain_r2_8", r2[1], 32'h0000_007C);
        $display("case chain: r1=%h/%h r2=%h/%h lat2=%0d/%0d", r1[0], r1[1][7:0], r2[0], r2[1][7:0], lat2[0], lat2[1]);

        issue(2'b01, 32'd100, 32'd7);          run_window(45, 0, 0, 1);
        chk("rst_ndone32", ndone[0], 32'd0);
        chk("rst_ndone8", ndone[1], 32'd0);
        chk("rst_res32_after", res32, 32'h0);
        $display("case reset_mid_div: ndone=%0d/%0d", ndone[0], ndone[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
